// File: rtl/wt_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// 2^INDEX_BITS lines of four 32-bit words; refills use four single-word reads.
// kseg1 addresses (addr[31:29] == UNCACHED_SEG) bypass the arrays entirely.
module wt_dcache #(
    parameter int unsigned INDEX_BITS   = 6,
    parameter logic [2:0]  UNCACHED_SEG = 3'b101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    input  logic [3:0]  cpu_data_wstrb,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_RESP,
        S_WR_REQ,
        S_WR_WAIT,
        S_UNC_REQ,
        S_UNC_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                req_wr_q;
    logic [1:0]          req_size_q;
    logic [31:0]         req_addr_q;
    logic [31:0]         req_wdata_q;
    logic [3:0]          req_wstrb_q;
    logic [31:0]         rdata_q;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES][4];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            wsel;
    logic                  uncached;
    logic                  hit;
    logic [31:0]           line_word;
    logic [31:0]           merged;

    logic                  data_ok;
    logic [31:0]           rdata_sel;
    logic                  arr_we;
    logic [1:0]            arr_word;
    logic [31:0]           arr_wdata;
    logic                  fill_done;

    assign idx       = req_addr_q[4 +: INDEX_BITS];
    assign tag       = req_addr_q[31 -: TAG_BITS];
    assign wsel      = req_addr_q[3:2];
    assign uncached  = (req_addr_q[31:29] == UNCACHED_SEG);
    assign hit       = !uncached && valid_q[idx] && (tag_q[idx] == tag);
    assign line_word = data_q[idx][wsel];

    assign cpu_data_addr_ok = cpu_data_req && (state_q == S_IDLE);
    assign cpu_data_data_ok = data_ok;
    // Read data is presented combinationally with data_ok and held afterwards.
    assign cpu_data_rdata   = data_ok ? rdata_sel : rdata_q;

    // Byte-wise merge of the latched store into the currently stored word.
    always_comb begin
        merged = line_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (req_wstrb_q[b]) merged[8*b +: 8] = req_wdata_q[8*b +: 8];
        end
    end

    // Next-state logic, upstream response and downstream request generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_ok   = 1'b0;
        rdata_sel = '0;
        arr_we    = 1'b0;
        arr_word  = '0;
        arr_wdata = '0;
        fill_done = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_data_addr_ok) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (req_wr_q) begin
                    state_d = S_WR_REQ;
                end else if (uncached) begin
                    state_d = S_UNC_REQ;
                end else if (hit) begin
                    data_ok   = 1'b1;
                    rdata_sel = line_word;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_REFILL_REQ;
                end
            end
            S_REFILL_REQ: begin
                mem_req  = 1'b1;
                mem_size = 2'd2;
                mem_addr = {req_addr_q[31:4], cnt_q, 2'b00};
                if (mem_addr_ok) state_d = S_REFILL_WAIT;
            end
            S_REFILL_WAIT: begin
                if (mem_data_ok) begin
                    arr_we    = 1'b1;
                    arr_word  = cnt_q;
                    arr_wdata = mem_rdata;
                    if (cnt_q == 2'd3) begin
                        fill_done = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = S_REFILL_REQ;
                    end
                end
            end
            S_RESP: begin
                data_ok   = 1'b1;
                rdata_sel = line_word;
                state_d   = S_IDLE;
            end
            S_WR_REQ: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_size  = req_size_q;
                mem_addr  = req_addr_q;
                mem_wdata = req_wdata_q;
                mem_wstrb = req_wstrb_q;
                if (mem_addr_ok) begin
                    if (hit) begin
                        arr_we    = 1'b1;
                        arr_word  = wsel;
                        arr_wdata = merged;
                    end
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (mem_data_ok) begin
                    data_ok = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_UNC_REQ: begin
                mem_req  = 1'b1;
                mem_size = req_size_q;
                mem_addr = req_addr_q;
                if (mem_addr_ok) state_d = S_UNC_WAIT;
            end
            S_UNC_WAIT: begin
                if (mem_data_ok) begin
                    data_ok   = 1'b1;
                    rdata_sel = mem_rdata;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, refill counter, accepted-request latch and held read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_wr_q    <= 1'b0;
            req_size_q  <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cpu_data_addr_ok) begin
                req_wr_q    <= cpu_data_wr;
                req_size_q  <= cpu_data_size;
                req_addr_q  <= cpu_data_addr;
                req_wdata_q <= cpu_data_wdata;
                req_wstrb_q <= cpu_data_wstrb;
            end
            if (data_ok) rdata_q <= rdata_sel;
        end
    end

    // Valid bits: cleared by reset, set only when the last refill beat lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_done) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_done) tag_q[idx] <= tag;
        if (arr_we) data_q[idx][arr_word] <= arr_wdata;
    end

endmodule

// File: doc/wt_dcache.md
Name: wt_dcache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Upstream: SRAM-like slave fed by the CPU-side write buffer, which forwards reads and drains buffered stores.
- Downstream: SRAM-like master to the memory/AXI bridge.
- One request in flight at a time; line refill is 4 sequential single-word reads.

Parameters:
- INDEX_BITS, 6, line index width; 2^INDEX_BITS lines of 16 bytes each.
- UNCACHED_SEG, 3'b101, value of addr[31:29] that selects the uncached (kseg1) bypass path.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cpu_data_req  in  1  request valid
- cpu_data_wr  in  1  1 = write
- cpu_data_size  in  2  0 = byte, 1 = half, 2 = word
- cpu_data_addr  in  32  byte address
- cpu_data_wdata  in  32  write data
- cpu_data_wstrb  in  4  byte enables
- cpu_data_rdata  out  32  read data, valid when cpu_data_data_ok
- cpu_data_addr_ok  out  1  request accepted this cycle
- cpu_data_data_ok  out  1  request completed this cycle
- mem_req  out  1  memory request valid
- mem_wr  out  1  memory write
- mem_size  out  2  memory access size
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_rdata  in  32  memory read data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory completed request

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; all valid bits = 0.
  - cpu_data_addr_ok = 0, cpu_data_data_ok = 0, cpu_data_rdata = 0, mem_req = 0; other mem_* outputs = 0.
  - Tag and data arrays are not reset.
  - Reset mid-refill or mid-write abandons the transaction; no partial line becomes valid.
- Address split: offset = addr[3:0], word select = addr[3:2], index = addr[4 +: INDEX_BITS], tag = remaining upper bits.
- Upstream handshake:
  - cpu_data_addr_ok = cpu_data_req && state == IDLE (combinational).
  - On acceptance, latch wr, size, addr, wdata, wstrb; go to LOOKUP.
  - Exactly one cpu_data_data_ok per accepted request, never in the same cycle as its cpu_data_addr_ok.
- Downstream handshake:
  - mem_req and all mem_* fields are held stable until mem_addr_ok.
  - mem_data_ok arrives no earlier than the cycle after mem_addr_ok.
  - At most one memory request outstanding.
- LOOKUP (one cycle):
  - Cached read hit: cpu_data_data_ok = 1, rdata = stored word; go to IDLE. Total latency 1 cycle after addr_ok.
  - Cached read miss: refill_cnt = 0; go to REFILL_REQ.
  - Write, cached or uncached: go to WR_REQ.
  - Uncached read: go to UNC_REQ.
- REFILL_REQ: mem_req = 1, mem_wr = 0, size = 2, mem_addr = {tag, index, refill_cnt, 2'b00}. On mem_addr_ok go to REFILL_WAIT.
- REFILL_WAIT: on mem_data_ok:
  - Write mem_rdata into data[index][refill_cnt].
  - If refill_cnt == 3: set tag, valid = 1; go to RESP.
  - Else refill_cnt + 1; go to REFILL_REQ.
- RESP: cpu_data_data_ok = 1, rdata = data[index][word select]; go to IDLE.
- WR_REQ:
  - mem_req = 1, mem_wr = 1, mem_addr, size, wdata and wstrb forwarded from the latched request.
  - On cached hit, merge wdata into the line bytewise per wstrb in the same cycle as mem_addr_ok.
  - Miss: line unchanged (no allocate). On mem_addr_ok go to WR_WAIT.
- WR_WAIT: on mem_data_ok, cpu_data_data_ok = 1; go to IDLE.
- UNC_REQ / UNC_WAIT: single read with the latched size and address, no cache update.
  - On mem_data_ok, cpu_data_data_ok = 1, rdata = mem_rdata; go to IDLE.
- cpu_data_rdata keeps its last value when data_ok = 0.
- Index aliasing: a refill overwrites any valid line at that index unconditionally.

Test Plan:
- Reset, then read 0x0000_1004 with memory returning 0x11, 0x22, 0x33, 0x44 for words 0..3:
  - Mem addresses are 0x1000, 0x1004, 0x1008, 0x100C in order.
  - Response rdata = 0x22.
  - Re-read of 0x1008 is a hit: data_ok exactly 1 cycle after addr_ok, rdata = 0x33, no mem_req.
- After the fill above, write 0x0000_1004 with wdata 0xAABBCCDD, wstrb 4'b0011:
  - One memory write with the same addr and wstrb.
  - Later read of 0x1004 hits with rdata = 0x0000CCDD (upper bytes 0x0000 from the original 0x22).
- Write miss at 0x0000_2000, then read 0x2000: read causes a full refill, proving no allocation on the write miss.
- Uncached read of 0xA000_0010, size 0:
  - Single mem_req with size 0.
  - rdata = mem_rdata.
  - Repeat read issues a memory access again.
- Memory holds mem_addr_ok low for 5 cycles: mem_* fields stay stable and cpu_data_addr_ok stays 0 while busy.
- Assert rst after the 2nd refill beat of 0x3000: state returns to IDLE, next read of 0x3000 misses and refills all 4 words.
